// File: rtl/toe_csr_ctrl.sv
// Avalon-MM control front end for the TCP offload engine: header staging registers,
// a command FIFO to the packet builder and a reply FIFO back to software.
// Optional level interrupt is compiled in with `define TOE_CSR_IRQ_EN.
module toe_csr_ctrl #(
   parameter int ID_W      = 8,
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     writedata,
   input  logic            write,
   input  logic            read,
   input  logic            chipselect,
   input  logic [3:0]      address,
   output logic [31:0]     readdata,
   output logic            cmd_valid,
   input  logic            cmd_ready,
   output logic [1:0]      cmd_code,
   output logic [ID_W-1:0] cmd_id,
   output logic [31:0]     cmd_ip_src,
   output logic [31:0]     cmd_ip_dst,
   output logic [47:0]     cmd_mac_src,
   output logic [47:0]     cmd_mac_dst,
   output logic [15:0]     cmd_port_src,
   output logic [15:0]     cmd_port_dst,
   input  logic            rsp_valid,
   output logic            rsp_ready,
   input  logic [7:0]      rsp_code,
   input  logic [ID_W-1:0] rsp_id,
   output logic            irq
);
   localparam int CA = $clog2(CMD_DEPTH);
   localparam int RA = $clog2(RSP_DEPTH);
   localparam int CW = 2 + ID_W + 32 + 32 + 48 + 48 + 16 + 16;
   localparam int RW = 8 + ID_W;
   localparam logic [CA:0]   CMD_FULL = (CA+1)'(CMD_DEPTH);
   localparam logic [RA:0]   RSP_FULL = (RA+1)'(RSP_DEPTH);
   localparam logic [CA-1:0] CPTR_ONE = 1;
   localparam logic [RA-1:0] RPTR_ONE = 1;
   localparam logic [CA:0]   CCNT_ONE = 1;
   localparam logic [RA:0]   RCNT_ONE = 1;

   logic [31:0]   readdata_q, readdata_d;
   logic [31:0]   ip_src_q, ip_dst_q;
   logic [47:0]   mac_src_q, mac_dst_q;
   logic [15:0]   port_src_q, port_dst_q;
   logic [1:0]    last_code_q;
   logic          ovf_q, ovf_d;
   logic [CW-1:0] cmd_mem_q [CMD_DEPTH];
   logic [CA-1:0] cmd_wp_q, cmd_rp_q;
   logic [CA:0]   cmd_cnt_q;
   logic [RW-1:0] rsp_mem_q [RSP_DEPTH];
   logic [RA-1:0] rsp_wp_q, rsp_rp_q;
   logic [RA:0]   rsp_cnt_q;
   logic          irq_en_q, irq_q;

   logic wr_en, rd_en, commit, cmd_full, cmd_empty, rsp_full, rsp_empty;
   logic cmd_push, cmd_pop, rsp_push, rsp_pop;
   logic [CW-1:0] cmd_head;
   logic [RW-1:0] rsp_head;

   assign wr_en     = chipselect && write;
   assign rd_en     = chipselect && read && !write;
   assign commit    = wr_en && (address == 4'h0);
   assign cmd_full  = (cmd_cnt_q == CMD_FULL);
   assign cmd_empty = (cmd_cnt_q == '0);
   assign rsp_full  = (rsp_cnt_q == RSP_FULL);
   assign rsp_empty = (rsp_cnt_q == '0);
   // A commit into a full FIFO still fits when the head leaves on the same edge.
   assign cmd_pop   = !cmd_empty && cmd_ready;
   assign cmd_push  = commit && (!cmd_full || cmd_pop);
   assign rsp_push  = rsp_valid && !rsp_full;
   assign rsp_pop   = rd_en && (address == 4'h2) && !rsp_empty;

   assign cmd_head  = cmd_mem_q[cmd_rp_q];
   assign rsp_head  = rsp_mem_q[rsp_rp_q];
   assign {cmd_code, cmd_id, cmd_ip_src, cmd_ip_dst, cmd_mac_src, cmd_mac_dst,
           cmd_port_src, cmd_port_dst} = cmd_head;
   assign cmd_valid = !cmd_empty;
   assign rsp_ready = !rsp_full;
   assign readdata  = readdata_q;

   always_comb begin
      readdata_d = readdata_q;
      if (rd_en) begin
         case (address)
            4'h0:    readdata_d = {last_code_q, 30'd0};
            4'h1:    readdata_d = {16'd0, 8'(cmd_cnt_q), 4'd0, ovf_q, !rsp_empty,
                                   cmd_empty, cmd_full};
            4'h2:    readdata_d = rsp_empty ? 32'd0 :
                                  {rsp_head[RW-1 -: 8], 8'd0, 16'(rsp_head[ID_W-1:0])};
            4'h3:    readdata_d = ip_src_q;
            4'h4:    readdata_d = ip_dst_q;
            4'h5:    readdata_d = mac_src_q[47:16];
            4'h6:    readdata_d = {mac_src_q[15:0], 16'd0};
            4'h7:    readdata_d = mac_dst_q[47:16];
            4'h8:    readdata_d = {mac_dst_q[15:0], 16'd0};
            4'h9:    readdata_d = {port_src_q, 16'd0};
            4'ha:    readdata_d = {port_dst_q, 16'd0};
`ifdef TOE_CSR_IRQ_EN
            4'hb:    readdata_d = {31'd0, irq_en_q};
`endif
            default: readdata_d = 32'd0;
         endcase
      end
      // Set wins over a simultaneous write-1-to-clear.
      ovf_d = ovf_q;
      if (wr_en && (address == 4'h1) && writedata[3]) ovf_d = 1'b0;
      if (commit && !cmd_push) ovf_d = 1'b1;
   end

   // FIFO storage carries no reset; validity lives in the counters.
   always_ff @(posedge clk) begin
      if (cmd_push)
         cmd_mem_q[cmd_wp_q] <= {writedata[31:30], writedata[ID_W-1:0], ip_src_q, ip_dst_q,
                                 mac_src_q, mac_dst_q, port_src_q, port_dst_q};
      if (rsp_push)
         rsp_mem_q[rsp_wp_q] <= {rsp_code, rsp_id};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         readdata_q  <= '0;
         ip_src_q    <= '0;
         ip_dst_q    <= '0;
         mac_src_q   <= '0;
         mac_dst_q   <= '0;
         port_src_q  <= '0;
         port_dst_q  <= '0;
         last_code_q <= '0;
         ovf_q       <= 1'b0;
         cmd_wp_q    <= '0;
         cmd_rp_q    <= '0;
         cmd_cnt_q   <= '0;
         rsp_wp_q    <= '0;
         rsp_rp_q    <= '0;
         rsp_cnt_q   <= '0;
      end else begin
         readdata_q <= readdata_d;
         ovf_q      <= ovf_d;
         if (wr_en) begin
            case (address)
               4'h0: last_code_q       <= writedata[31:30];
               4'h3: ip_src_q          <= writedata;
               4'h4: ip_dst_q          <= writedata;
               4'h5: mac_src_q[47:16]  <= writedata;
               4'h6: mac_src_q[15:0]   <= writedata[31:16];
               4'h7: mac_dst_q[47:16]  <= writedata;
               4'h8: mac_dst_q[15:0]   <= writedata[31:16];
               4'h9: port_src_q        <= writedata[31:16];
               4'ha: port_dst_q        <= writedata[31:16];
               default: ;
            endcase
         end
         if (cmd_push) cmd_wp_q <= cmd_wp_q + CPTR_ONE;
         if (cmd_pop)  cmd_rp_q <= cmd_rp_q + CPTR_ONE;
         if (cmd_push && !cmd_pop)      cmd_cnt_q <= cmd_cnt_q + CCNT_ONE;
         else if (cmd_pop && !cmd_push) cmd_cnt_q <= cmd_cnt_q - CCNT_ONE;
         if (rsp_push) rsp_wp_q <= rsp_wp_q + RPTR_ONE;
         if (rsp_pop)  rsp_rp_q <= rsp_rp_q + RPTR_ONE;
         if (rsp_push && !rsp_pop)      rsp_cnt_q <= rsp_cnt_q + RCNT_ONE;
         else if (rsp_pop && !rsp_push) rsp_cnt_q <= rsp_cnt_q - RCNT_ONE;
      end
   end

`ifdef TOE_CSR_IRQ_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_en && (address == 4'hb)) irq_en_q <= writedata[0];
         irq_q <= irq_en_q && (!rsp_empty || ovf_q);
      end
   end
`else
   assign irq_en_q = 1'b0;
   assign irq_q    = 1'b0;
`endif
   assign irq = irq_q;
endmodule

// File: tb/tb_toe_csr_ctrl.sv
// Directed and random bench for toe_csr_ctrl against a queue-based model of the
// register map, command FIFO and reply FIFO.
module tb_toe_csr_ctrl;
   localparam int ID_W  = 8;
   localparam int CMD_D = 4;
   localparam int RSP_D = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [31:0]     writedata;
   logic            write, read, chipselect;
   logic [3:0]      address;
   logic [31:0]     readdata;
   logic            cmd_valid, cmd_ready;
   logic [1:0]      cmd_code;
   logic [ID_W-1:0] cmd_id;
   logic [31:0]     cmd_ip_src, cmd_ip_dst;
   logic [47:0]     cmd_mac_src, cmd_mac_dst;
   logic [15:0]     cmd_port_src, cmd_port_dst;
   logic            rsp_valid, rsp_ready;
   logic [7:0]      rsp_code;
   logic [ID_W-1:0] rsp_id;
   logic            irq;

   toe_csr_ctrl #(.ID_W(ID_W), .CMD_DEPTH(CMD_D), .RSP_DEPTH(RSP_D)) dut (
      .clk(clk), .rst(rst), .writedata(writedata), .write(write), .read(read),
      .chipselect(chipselect), .address(address), .readdata(readdata),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_id(cmd_id),
      .cmd_ip_src(cmd_ip_src), .cmd_ip_dst(cmd_ip_dst), .cmd_mac_src(cmd_mac_src),
      .cmd_mac_dst(cmd_mac_dst), .cmd_port_src(cmd_port_src), .cmd_port_dst(cmd_port_dst),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code), .rsp_id(rsp_id),
      .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]      code;
      logic [ID_W-1:0] id;
      logic [31:0]     ip_s, ip_d;
      logic [47:0]     mac_s, mac_d;
      logic [15:0]     ps, pd;
   } cmd_t;

   cmd_t              exp_cmd_q[$];
   logic [8+ID_W-1:0] exp_rsp_q[$];
   logic [31:0] m_ip_s, m_ip_d, m_readdata;
   logic [47:0] m_mac_s, m_mac_d;
   logic [15:0] m_ps, m_pd;
   logic [1:0]  m_last_code;
   logic        m_ovf, m_irq_en, m_irq;
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_cmd_q.delete();
      exp_rsp_q.delete();
      {m_ip_s, m_ip_d, m_mac_s, m_mac_d, m_ps, m_pd} = '0;
      m_readdata = 0; m_last_code = 0; m_ovf = 0; m_irq_en = 0; m_irq = 0;
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] a);
      logic [31:0] v;
      v = 32'd0;
      case (a)
         4'h0: v = {m_last_code, 30'd0};
         4'h1: v = {16'd0, 8'(exp_cmd_q.size()), 4'd0, m_ovf, exp_rsp_q.size() > 0,
                    exp_cmd_q.size() == 0, exp_cmd_q.size() == CMD_D};
         4'h2: if (exp_rsp_q.size() > 0)
                  v = {exp_rsp_q[0][8+ID_W-1 -: 8], 8'd0, 16'(exp_rsp_q[0][ID_W-1:0])};
         4'h3: v = m_ip_s;
         4'h4: v = m_ip_d;
         4'h5: v = m_mac_s[47:16];
         4'h6: v = {m_mac_s[15:0], 16'd0};
         4'h7: v = m_mac_d[47:16];
         4'h8: v = {m_mac_d[15:0], 16'd0};
         4'h9: v = {m_ps, 16'd0};
         4'ha: v = {m_pd, 16'd0};
`ifdef TOE_CSR_IRQ_EN
         4'hb: v = {31'd0, m_irq_en};
`endif
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   // Drives one cycle of bus and builder inputs, advances the model, then checks outputs.
   task automatic cycle(input logic c, input logic w, input logic r, input logic [3:0] a,
                        input logic [31:0] d, input logic crdy, input logic rv,
                        input logic [7:0] rc, input logic [ID_W-1:0] ri);
      logic do_wr, do_rd, pop, accept, rpop, rpush, nxt_irq;
      logic [31:0] exp_rd;
      cmd_t ent;
      chipselect = c; write = w; read = r; address = a; writedata = d;
      cmd_ready = crdy; rsp_valid = rv; rsp_code = rc; rsp_id = ri;
      do_wr   = c && w;
      do_rd   = c && r && !w;
      pop     = crdy && exp_cmd_q.size() > 0;
      exp_rd  = do_rd ? model_read(a) : m_readdata;
      rpop    = do_rd && a == 4'h2 && exp_rsp_q.size() > 0;
      rpush   = rv && exp_rsp_q.size() < RSP_D;
      nxt_irq = m_irq_en && (exp_rsp_q.size() > 0 || m_ovf);
      accept  = exp_cmd_q.size() < CMD_D || pop;
      ent     = '{d[31:30], d[ID_W-1:0], m_ip_s, m_ip_d, m_mac_s, m_mac_d, m_ps, m_pd};
      if (pop) void'(exp_cmd_q.pop_front());
      if (rpop) void'(exp_rsp_q.pop_front());
      if (rpush) exp_rsp_q.push_back({rc, ri});
      if (do_wr) begin
         case (a)
            4'h0: begin
               m_last_code = d[31:30];
               if (accept) exp_cmd_q.push_back(ent);
               else m_ovf = 1'b1;
            end
            4'h1: if (d[3]) m_ovf = 1'b0;
            4'h3: m_ip_s = d;
            4'h4: m_ip_d = d;
            4'h5: m_mac_s[47:16] = d;
            4'h6: m_mac_s[15:0] = d[31:16];
            4'h7: m_mac_d[47:16] = d;
            4'h8: m_mac_d[15:0] = d[31:16];
            4'h9: m_ps = d[31:16];
            4'ha: m_pd = d[31:16];
`ifdef TOE_CSR_IRQ_EN
            4'hb: m_irq_en = d[0];
`endif
            default: ;
         endcase
      end
      m_readdata = exp_rd;
`ifdef TOE_CSR_IRQ_EN
      m_irq = nxt_irq;
`else
      m_irq = 1'b0 & nxt_irq;
`endif
      @(posedge clk); #1;
      check("readdata", readdata, m_readdata);
      check("cmd_valid", cmd_valid, exp_cmd_q.size() > 0);
      if (exp_cmd_q.size() > 0)
         check("cmd_head", {cmd_code, cmd_id, cmd_ip_src, cmd_ip_dst, cmd_mac_src,
                            cmd_mac_dst, cmd_port_src, cmd_port_dst}, exp_cmd_q[0]);
      check("rsp_ready", rsp_ready, exp_rsp_q.size() < RSP_D);
      check("irq", irq, m_irq);
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      cycle(1, 1, 0, a, d, 0, 0, 8'd0, '0);
   endtask
   task automatic bus_read(input logic [3:0] a);
      cycle(1, 0, 1, a, 32'd0, 0, 0, 8'd0, '0);
   endtask
   task automatic idle();
      cycle(0, 0, 0, 4'h0, 32'd0, 0, 0, 8'd0, '0);
   endtask

   task automatic do_reset();
      rst = 1'b1; chipselect = 0; write = 0; read = 0; address = 0; writedata = 0;
      cmd_ready = 0; rsp_valid = 0; rsp_code = 0; rsp_id = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      check("rst_readdata", readdata, 32'd0);
      check("rst_cmd_valid", cmd_valid, 1'b0);
      check("rst_rsp_ready", rsp_ready, 1'b1);
      check("rst_irq", irq, 1'b0);
   endtask

   initial begin
      logic [3:0] a;
      int n;
      do_reset();

      bus_read(4'h1);
      check("status_after_reset", readdata, 32'h0000_0002);

      bus_write(4'h3, 32'h0A00_0001);
      bus_write(4'h9, 32'h1F90_0000);
      bus_write(4'h0, 32'h4000_0005);
      check("commit_valid", cmd_valid, 1'b1);
      check("commit_code", cmd_code, 2'd1);
      check("commit_id", cmd_id, 8'd5);
      check("commit_ip_src", cmd_ip_src, 32'h0A00_0001);
      check("commit_port_src", cmd_port_src, 16'h1F90);
      bus_read(4'h0);
      check("last_code", readdata, 32'h4000_0000);

      for (int i = 0; i < 4; i++) bus_write(4'h0, 32'h8000_0010 + i);
      bus_read(4'h1);
      check("status_overflow", readdata, 32'h0000_0409);
      bus_write(4'h1, 32'h0000_0008);
      bus_read(4'h1);
      check("status_ovf_cleared", readdata, 32'h0000_0401);

      cycle(1, 1, 0, 4'h0, 32'hC000_0007, 1, 0, 8'd0, '0);
      bus_read(4'h1);
      check("full_commit_with_pop", readdata, 32'h0000_0401);
      n = 0;
      while (exp_cmd_q.size() > 0 && n < 16) begin
         cycle(0, 0, 0, 4'h0, 32'd0, 1, 0, 8'd0, '0);
         n++;
      end
      check("drain_bound", n < 16, 1'b1);

      cycle(0, 0, 0, 4'h0, 32'd0, 0, 1, 8'hA5, 8'd3);
      bus_read(4'h2);
      check("reply_first", readdata, 32'hA500_0003);
      bus_read(4'h2);
      check("reply_empty", readdata, 32'd0);
      bus_read(4'h1);
      check("reply_avail_clear", readdata[2], 1'b0);

`ifdef TOE_CSR_IRQ_EN
      bus_write(4'hb, 32'h1);
      cycle(0, 0, 0, 4'h0, 32'd0, 0, 1, 8'h11, 8'd9);
      idle();
      check("irq_set", irq, 1'b1);
      bus_read(4'h2);
      idle();
      check("irq_clear", irq, 1'b0);
`else
      bus_write(4'hb, 32'h1);
      bus_read(4'hb);
      check("irq_en_absent", readdata, 32'd0);
`endif

      for (int i = 0; i < 600; i++) begin
         a = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
         cycle($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               a, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               8'($urandom), ID_W'($urandom));
      end

      for (int i = 0; i < 3; i++) bus_write(4'h0, $urandom);
      cycle(0, 0, 0, 4'h0, 32'd0, 0, 1, 8'h5A, 8'd1);
      do_reset();
      bus_read(4'h1);
      check("status_after_mid_reset", readdata, 32'h0000_0002);
      bus_read(4'h2);
      check("reply_after_mid_reset", readdata, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/toe_csr_ctrl.md
# toe_csr_ctrl

Parametrised Avalon-MM control front end for the TCP offload engine. It holds header staging registers and queues connection requests in a command FIFO for the packet builder. Builder replies come back through a reply FIFO that software reads over the bus. It extends the single-request register file with queuing, per-request IDs, overflow detection and an optional interrupt.

## Interface
- `ID_W`, default 8: request ID width, 1..16.
- `CMD_DEPTH`, default 4: command FIFO entries, power of 2, ≥2.
- `RSP_DEPTH`, default 4: reply FIFO entries, power of 2, ≥2.
- `clk` in 1: sole clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `writedata` in 32: Avalon-MM write data.
- `write` in 1: Avalon-MM write strobe.
- `read` in 1: Avalon-MM read strobe.
- `chipselect` in 1: Avalon-MM select; `write`/`read` are ignored when low.
- `address` in 4: word address.
- `readdata` out 32: registered read data.
- `cmd_valid` out 1: command FIFO head is valid.
- `cmd_ready` in 1: builder accepts the head.
- `cmd_code` out 2: request code.
- `cmd_id` out ID_W: request ID.
- `cmd_ip_src`, `cmd_ip_dst` out 32 each.
- `cmd_mac_src`, `cmd_mac_dst` out 48 each.
- `cmd_port_src`, `cmd_port_dst` out 16 each.
- `rsp_valid` in 1: builder reply strobe.
- `rsp_ready` out 1: reply FIFO not full.
- `rsp_code` in 8: reply code.
- `rsp_id` in ID_W: ID of the request being replied to.
- `irq` out 1: interrupt, level-sensitive.

## Operation
- Register map (word address):
  - 0x0 COMMIT. Write pushes {writedata[31:30], writedata[ID_W-1:0], all staging registers} into the command FIFO. Read returns {last code, 30'd0}.
  - 0x1 STATUS, read-only except bit 3:
    - [0] cmd full, [1] cmd empty, [2] reply available, [3] overflow (sticky), [15:8] cmd fill count.
    - Writing 1 to bit 3 clears overflow.
  - 0x2 REPLY. Read returns {rsp_code, 8'd0, zero-extended id in [15:0]} and pops the reply FIFO. A read while the FIFO is empty returns 0 and does not pop. Writes are ignored.
  - 0x3 ip_src, 0x4 ip_dst.
  - 0x5 mac_src[47:16], 0x6 mac_src[15:0] in writedata[31:16].
  - 0x7 mac_dst[47:16], 0x8 mac_dst[15:0] in writedata[31:16].
  - 0x9 port_src, 0xa port_dst, both in [31:16].
  - 0xb IRQ_EN, bit 0 (see Configuration).
  - Unmapped addresses read 0 and ignore writes.
- Staging registers read back in the same bit positions they are written. They are not cleared by a commit, so repeated commits reuse the fields.
- Command FIFO:
  - First-word-fall-through; the `cmd_*` fields present the head while `cmd_valid` = not empty.
  - A pop occurs when `cmd_valid` && `cmd_ready`.
  - A commit is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the commit is dropped and overflow is set.
- Reply FIFO:
  - Pushes on `rsp_valid` && `rsp_ready`.
  - A `rsp_valid` while full is the builder's error; the entry is dropped and the FIFO is unchanged.
- If `write` and `read` are both high, the write is performed and the read is ignored; `readdata` holds its value.
- Pointers wrap modulo depth. Fill counters are log2(depth)+1 bits wide.

## Timing
- Reset values:
  - `readdata`, staging registers, last code = 0.
  - Both FIFOs empty: `cmd_valid`=0, `rsp_ready`=1.
  - Overflow = 0, IRQ_EN = 0, `irq` = 0.
- Read latency is 1 cycle: `readdata` updates on the edge after `read` and then holds until the next read.
- A commit in cycle N makes `cmd_valid` high in N+1 when the FIFO was empty. There is no same-cycle bypass.
- A push and pop together on an empty FIFO are impossible (pop requires valid). On a full FIFO, push+pop keeps the count at CMD_DEPTH.
- A REPLY read pops the entry at the same edge that registers it into `readdata`. STATUS bit 2 reflects the updated state from the next cycle.
- A reply pushed in cycle N is visible through STATUS/REPLY reads issued in N+1.
- Overflow set and clear in the same cycle: set wins.
- `rst` mid-operation empties both FIFOs and discards queued commands. An in-flight builder handshake is abandoned.

## Configuration
- `TOE_CSR_IRQ_EN` defined:
  - `irq` is registered and high when IRQ_EN[0] && (reply available || overflow).
  - It updates one cycle after the underlying condition changes.
  - 0xb reads/writes bit 0.
- Not defined: `irq` is tied to 0, 0xb reads 0 and ignores writes, and no IRQ logic is synthesised.

## Test plan
- Reset, then read 0x1 → readdata = 0x0000_0002 (cmd empty only); `cmd_valid`=0.
- Write 0x3 = 0x0A00_0001, 0x9 = 0x1F90_0000, then 0x0 = 0x4000_0005 → next cycle `cmd_valid`=1, `cmd_code`=1, `cmd_id`=5, `cmd_ip_src`=0x0A000001, `cmd_port_src`=0x1F90.
- With `cmd_ready`=0, do 5 commits at CMD_DEPTH=4 → STATUS = 0x0000_0409 (full, overflow, count 4). Write 0x1 = 0x8 → overflow clears.
- Full FIFO, commit in the same cycle as `cmd_ready`=1 → commit accepted, count stays 4, no overflow.
- Push reply code 0xA5 id 3, then read 0x2 twice → first 0xA500_0003, second 0; STATUS bit 2 = 0 afterwards.
- With `TOE_CSR_IRQ_EN`: write 0xb = 1, push a reply → `irq`=1 one cycle later. Pop via 0x2 read → `irq`=0 within 2 cycles.
